// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 device-to-host receiver for the keyboard scancode path. The PS/2
//   clock and data lines are synchronised, the clock is glitch-filtered, and
//   11-bit frames (start, 8 data LSB first, odd parity, stop) are rebuilt on
//   each filtered falling edge. E0/F0 prefix bytes are folded into flags, and
//   one kb_interrupt pulse is emitted per completed key event.
//
// Optional feature macro: PS2_RX_ERRFLAG_EN
//   When defined, the frame_error port exists and pulses for one clk whenever
//   a frame is discarded (parity error, stop bit 0, or timeout).
//
// Parameters
//   FILTER_LEN      clk cycles the synchronised ps2clk must hold a new level
//                   before the filtered clock follows
//   TIMEOUT_CYCLES  clk cycles without a filtered fall mid-frame before abort
//
// Ports
//   clk          in     system clock
//   rst          in     synchronous, active-high reset
//   enable_rcv   in     1 = receive; 0 = host owns the bus, abort and ignore
//   ps2clk_ext   inout  PS/2 clock line, read only (driven 1'bz)
//   ps2data_ext  inout  PS/2 data line, read only (driven 1'bz)
//   kb_interrupt out    one-clk pulse: new key event valid
//   scancode     out    last delivered scancode, held until the next event
//   released     out    event was preceded by F0
//   extended     out    event was preceded by E0
//   frame_error  out    one-clk pulse per discarded frame (PS2_RX_ERRFLAG_EN)

module ps2_scancode_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 28000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_rcv,
    inout  wire        ps2clk_ext,
    inout  wire        ps2data_ext,
    output logic       kb_interrupt,
    output logic [7:0] scancode,
    output logic       released,
    output logic       extended
`ifdef PS2_RX_ERRFLAG_EN
    ,
    output logic       frame_error
`endif
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // The receiver never drives the bus.
    assign ps2clk_ext  = 1'bz;
    assign ps2data_ext = 1'bz;

    logic [1:0]     r_clk_sync;
    logic [1:0]     r_dat_sync;
    logic           r_clk_filt;
    logic [FCW-1:0] r_filt_cnt;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic [TCW-1:0] r_to_cnt;
    logic           r_e0;
    logic           r_f0;
    logic           r_kb_int;
    logic [7:0]     r_scancode;
    logic           r_released;
    logic           r_extended;

    logic w_clk_s;
    logic w_dat_s;
    logic w_filt_flip;
    logic w_fall;
    logic w_frame_ok;
    logic w_frame_bad;
    logic w_timeout;
    logic w_discard;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2clk_ext};
            r_dat_sync <= {r_dat_sync[0], ps2data_ext};
        end
    end

    assign w_clk_s = r_clk_sync[1];
    assign w_dat_s = r_dat_sync[1];

    // The filtered clock flips on the FILTER_LEN-th consecutive sample that
    // differs from it; any agreeing sample restarts the count.
    assign w_filt_flip = (w_clk_s != r_clk_filt) && (r_filt_cnt == FILT_LAST);
    assign w_fall      = w_filt_flip && r_clk_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (w_clk_s == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (w_filt_flip) begin
            r_clk_filt <= w_clk_s;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + FCW'(1);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and frame verdicts. enable_rcv=0 overrides everything,
    // including a stop-bit fall in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_ok  = 1'b0;
        w_frame_bad = 1'b0;
        w_timeout   = 1'b0;
        if (!enable_rcv) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_dat_s) begin
                        w_state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_state_nxt = S_STOP;
                end
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    if (w_dat_s && (^{r_shift, r_parity})) begin
                        w_frame_ok = 1'b1;
                    end else begin
                        w_frame_bad = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if ((r_state != S_IDLE) && (r_to_cnt == TO_LAST)) begin
            w_state_nxt = S_IDLE;
            w_timeout   = 1'b1;
        end
    end

    assign w_discard = w_frame_bad | w_timeout;

    // Frame datapath: bit counter, LSB-first shifter, parity capture.
    always_ff @(posedge clk) begin
        if (enable_rcv && w_fall) begin
            case (r_state)
                S_IDLE: begin
                    r_bit_cnt <= 3'd0;
                end
                S_DATA: begin
                    r_shift   <= {w_dat_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                S_PARITY: begin
                    r_parity <= w_dat_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Timeout counter: runs only mid-frame, reloaded by every fall.
    always_ff @(posedge clk) begin
        if (rst || !enable_rcv || (r_state == S_IDLE) || w_fall) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + TCW'(1);
        end
    end

    // Prefix folding and event delivery, one clk after the stop-bit fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0       <= 1'b0;
            r_f0       <= 1'b0;
            r_kb_int   <= 1'b0;
            r_scancode <= 8'h00;
            r_released <= 1'b0;
            r_extended <= 1'b0;
        end else begin
            r_kb_int <= 1'b0;
            if (!enable_rcv || w_discard) begin
                r_e0 <= 1'b0;
                r_f0 <= 1'b0;
            end else if (w_frame_ok) begin
                case (r_shift)
                    8'hE0: r_e0 <= 1'b1;
                    8'hF0: r_f0 <= 1'b1;
                    default: begin
                        r_scancode <= r_shift;
                        r_released <= r_f0;
                        r_extended <= r_e0;
                        r_kb_int   <= 1'b1;
                        r_e0       <= 1'b0;
                        r_f0       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign kb_interrupt = r_kb_int;
    assign scancode     = r_scancode;
    assign released     = r_released;
    assign extended     = r_extended;

`ifdef PS2_RX_ERRFLAG_EN
    logic r_frame_error;

    // A bus takeover via enable_rcv=0 is not an error; w_discard is already
    // masked by enable_rcv in the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_error <= 1'b0;
        end else begin
            r_frame_error <= w_discard;
        end
    end

    assign frame_error = r_frame_error;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

    localparam int HALF = 40;   // device clock half-period in clk cycles
    localparam int TO   = 600;  // timeout used for this build

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst        = 1'b1;
    logic enable_rcv = 1'b1;
    logic drv_clk    = 1'b1;
    logic drv_dat    = 1'b1;

    wire ps2clk_w;
    wire ps2data_w;
    assign ps2clk_w  = drv_clk;
    assign ps2data_w = drv_dat;

    logic       kb_interrupt;
    logic [7:0] scancode;
    logic       released;
    logic       extended;
`ifdef PS2_RX_ERRFLAG_EN
    logic       frame_error;
`endif

    ps2_scancode_rx #(
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_rcv  (enable_rcv),
        .ps2clk_ext  (ps2clk_w),
        .ps2data_ext (ps2data_w),
        .kb_interrupt(kb_interrupt),
        .scancode    (scancode),
        .released    (released),
        .extended    (extended)
`ifdef PS2_RX_ERRFLAG_EN
        ,
        .frame_error (frame_error)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] code;
        logic       rel;
        logic       ext;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  mon_ev;
    logic prev_int = 1'b0;

    // Reference model of the key-event layer: prefix flags plus last event.
    bit         m_e0 = 0;
    bit         m_f0 = 0;
    logic [7:0] m_code = 8'h00;
    logic       m_rel = 1'b0;
    logic       m_ext = 1'b0;
    int         exp_err = 0;
    int         got_err = 0;
    int         pushed = 0;
    int         seen = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_frame(logic [7:0] b, bit good);
        if (!good) begin
            m_e0 = 0;
            m_f0 = 0;
            exp_err++;
        end else if (b == 8'hE0) begin
            m_e0 = 1;
        end else if (b == 8'hF0) begin
            m_f0 = 1;
        end else begin
            exp_q.push_back('{code: b, rel: m_f0, ext: m_e0});
            m_code = b;
            m_rel  = m_f0;
            m_ext  = m_e0;
            m_e0   = 0;
            m_f0   = 0;
            pushed++;
        end
    endtask

    // Device-side bit clocking: data changes while the clock is high.
    task automatic send_bits(logic [10:0] bits, int n, int abort_at);
        for (int i = 0; i < n; i++) begin
            drv_dat = bits[i];
            tick(HALF);
            if (i == abort_at) enable_rcv = 1'b0;
            drv_clk = 1'b0;
            tick(HALF);
            drv_clk = 1'b1;
        end
        tick(HALF);
        drv_dat    = 1'b1;
        enable_rcv = 1'b1;
    endtask

    function automatic logic [10:0] frame_of(logic [7:0] b, bit bad_par, bit bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic check_hold();
        check("hold_scancode", 32'(scancode), 32'(m_code));
        check("hold_released", 32'(released), 32'(m_rel));
        check("hold_extended", 32'(extended), 32'(m_ext));
    endtask

    task automatic send_byte(logic [7:0] b, bit bad_par, bit bad_stop);
        model_frame(b, !(bad_par || bad_stop));
        send_bits(frame_of(b, bad_par, bad_stop), 11, -1);
        tick(50);
        check_hold();
    endtask

    // Monitor: every kb_interrupt pops one expected event.
    always @(negedge clk) begin
        if (rst) begin
            prev_int = 1'b0;
        end else begin
            if (kb_interrupt) begin
                seen++;
                check("pulse_width", 32'(prev_int), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got scancode %0h expected no event", scancode);
                end else begin
                    mon_ev = exp_q.pop_front();
                    check("ev_scancode", 32'(scancode), 32'(mon_ev.code));
                    check("ev_released", 32'(released), 32'(mon_ev.rel));
                    check("ev_extended", 32'(extended), 32'(mon_ev.ext));
                end
            end
            prev_int = kb_interrupt;
`ifdef PS2_RX_ERRFLAG_EN
            if (frame_error) got_err++;
`endif
        end
    end

    initial begin
        logic [7:0] b;
        int         r;
        bit         bp;
        bit         bs;

        tick(4);
        check("rst_kb_interrupt", 32'(kb_interrupt), 32'd0);
        check("rst_scancode", 32'(scancode), 32'h00);
        check("rst_released", 32'(released), 32'd0);
        check("rst_extended", 32'(extended), 32'd0);
        rst = 1'b0;
        tick(20);

        // Plain make code, break sequence, extended break, then plain again.
        send_byte(8'h1C, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h75, 0, 0);
        send_byte(8'h1C, 0, 0);

        // Parity error after a pending F0: dropped, flag cleared.
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 1, 0);
        send_byte(8'h1C, 0, 0);

        // Stop bit 0 after a pending E0.
        send_byte(8'hE0, 0, 0);
        send_byte(8'h6B, 0, 1);
        send_byte(8'h6B, 0, 0);

        // Truncated frame followed by silence longer than the timeout.
        send_byte(8'hF0, 0, 0);
        m_e0 = 0;
        m_f0 = 0;
        exp_err++;
        send_bits(frame_of(8'h29, 0, 0), 5, -1);
        tick(TO + 10);
        send_byte(8'h29, 0, 0);

        // Short low glitches on the clock with data low must not start a frame.
        drv_dat = 1'b0;
        for (int g = 0; g < 4; g++) begin
            drv_clk = 1'b0;
            tick(3);
            drv_clk = 1'b1;
            tick(20);
        end
        drv_dat = 1'b1;
        tick(20);
        send_byte(8'h5A, 0, 0);

        // Host takes the bus during the parity bit of an E0.
        m_e0 = 0;
        m_f0 = 0;
        send_bits(frame_of(8'hE0, 0, 0), 11, 9);
        tick(50);
        send_byte(8'h74, 0, 0);

        // Reset in mid-frame with a pending F0.
        send_byte(8'hF0, 0, 0);
        send_bits(frame_of(8'h33, 0, 0), 4, -1);
        rst = 1'b1;
        tick(3);
        rst    = 1'b0;
        m_e0   = 0;
        m_f0   = 0;
        m_code = 8'h00;
        m_rel  = 1'b0;
        m_ext  = 1'b0;
        tick(20);
        check_hold();
        send_byte(8'h16, 0, 0);

        // Randomised byte stream with occasional corrupted frames.
        for (int k = 0; k < 30; k++) begin
            r  = $urandom_range(0, 99);
            if (r < 20)      b = 8'hE0;
            else if (r < 40) b = 8'hF0;
            else             b = 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 9) == 0);
            bs = ($urandom_range(0, 19) == 0);
            send_byte(b, bp, bs);
        end

        tick(100);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("pulse_count", 32'(seen), 32'(pushed));
`ifdef PS2_RX_ERRFLAG_EN
        check("frame_error_count", 32'(got_err), 32'(exp_err));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
